// File: rtl/register_bank_pkg.sv
// Shared definitions for the parametrised register bank: function-select
// codes and the read-select width helper.
package register_bank_pkg;

   localparam logic [2:0] FS_DEC   = 3'b000;
   localparam logic [2:0] FS_INC   = 3'b001;
   localparam logic [2:0] FS_LOAD  = 3'b010;
   localparam logic [2:0] FS_CLR   = 3'b011;
   localparam logic [2:0] FS_LOADL = 3'b100;
   localparam logic [2:0] FS_LOADH = 3'b101;
   localparam logic [2:0] FS_SHL   = 3'b110;
   localparam logic [2:0] FS_SHR   = 3'b111;

   // Never returns 0, so a select port always has at least one bit.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/param_register_cell.sv
// One WIDTH-bit register with its sticky boundary flag, driven by the shared
// function select when enabled.
module param_register_cell
   import register_bank_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int SATURATE = 0
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] I,
   input  logic [2:0]       FunSel,
   input  logic             E,
   output logic [WIDTH-1:0] Q,
   output logic             Flag
);

   localparam int HALF = WIDTH / 2;

   logic [WIDTH-1:0] q_reg;
   logic             flag_reg;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         q_reg    <= '0;
         flag_reg <= 1'b0;
      end else if (E) begin
         case (FunSel)
            FS_DEC: begin
               if (q_reg == '0) begin
                  flag_reg <= 1'b1;
                  if (SATURATE != 0) q_reg <= '0;
                  else               q_reg <= '1;
               end else begin
                  q_reg <= q_reg - WIDTH'(1);
               end
            end
            FS_INC: begin
               if (q_reg == '1) begin
                  flag_reg <= 1'b1;
                  if (SATURATE != 0) q_reg <= '1;
                  else               q_reg <= '0;
               end else begin
                  q_reg <= q_reg + WIDTH'(1);
               end
            end
            FS_LOAD: begin
               q_reg    <= I;
               flag_reg <= 1'b0;
            end
            FS_CLR: begin
               q_reg    <= '0;
               flag_reg <= 1'b0;
            end
            // Both half loads take their data from the low half of I.
            FS_LOADL: q_reg[HALF-1:0]     <= I[HALF-1:0];
            FS_LOADH: q_reg[WIDTH-1:HALF] <= I[HALF-1:0];
            FS_SHL: begin
               q_reg <= {q_reg[WIDTH-2:0], 1'b0};
               if (q_reg[WIDTH-1]) flag_reg <= 1'b1;
            end
            FS_SHR: begin
               q_reg <= {1'b0, q_reg[WIDTH-1:1]};
               if (q_reg[0]) flag_reg <= 1'b1;
            end
            default: begin
               q_reg    <= q_reg;
               flag_reg <= flag_reg;
            end
         endcase
      end
   end

   assign Q    = q_reg;
   assign Flag = flag_reg;

endmodule

// File: rtl/param_register_bank.sv
// Bank of NUM_REGS register cells sharing data and function select, with two
// independent combinational read ports.
module param_register_bank
   import register_bank_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_REGS = 4,
   parameter int SATURATE = 0
) (
   input  logic                                Clock,
   input  logic                                Reset,
   input  logic [WIDTH-1:0]                    I,
   input  logic [2:0]                          FunSel,
   input  logic [NUM_REGS-1:0]                 RegEn,
   input  logic [sel_width(NUM_REGS)-1:0]      OutASel,
   input  logic [sel_width(NUM_REGS)-1:0]      OutBSel,
   output logic [WIDTH-1:0]                    OutA,
   output logic [WIDTH-1:0]                    OutB,
   output logic [NUM_REGS-1:0]                 Flag
);

   localparam int SEL_W = sel_width(NUM_REGS);

   logic [WIDTH-1:0] q_arr [NUM_REGS];

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
      param_register_cell #(
         .WIDTH    (WIDTH),
         .SATURATE (SATURATE)
      ) u_cell (
         .Clock  (Clock),
         .Reset  (Reset),
         .I      (I),
         .FunSel (FunSel),
         .E      (RegEn[gi]),
         .Q      (q_arr[gi]),
         .Flag   (Flag[gi])
      );
   end

   // Selects with no matching register fall through to zero.
   always_comb begin
      OutA = '0;
      OutB = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (OutASel == SEL_W'(k)) OutA = q_arr[k];
         if (OutBSel == SEL_W'(k)) OutB = q_arr[k];
      end
   end

endmodule

// File: tb/tb_param_register_bank.sv
// Self-checking bench: wrap, saturate and 3-register builds driven in lockstep,
// expectations queued at stimulus time and popped when outputs are sampled.
module tb_param_register_bank;
   import register_bank_pkg::*;

   typedef struct packed {
      logic [15:0] val;
      logic        flag;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [15:0] data;
   logic [2:0]  fs;
   logic [3:0]  en;
   logic [1:0]  sel_a;
   logic [1:0]  sel_b;

   logic [15:0] a0, b0, a_s, b_s, a3, b3;
   logic [3:0]  f0, f_s;
   logic [2:0]  f3;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   param_register_bank #(.WIDTH(16), .NUM_REGS(4), .SATURATE(0)) dut (
      .Clock(clk), .Reset(rst), .I(data), .FunSel(fs), .RegEn(en),
      .OutASel(sel_a), .OutBSel(sel_b), .OutA(a0), .OutB(b0), .Flag(f0));

   param_register_bank #(.WIDTH(16), .NUM_REGS(4), .SATURATE(1)) dut_sat (
      .Clock(clk), .Reset(rst), .I(data), .FunSel(fs), .RegEn(en),
      .OutASel(sel_a), .OutBSel(sel_b), .OutA(a_s), .OutB(b_s), .Flag(f_s));

   param_register_bank #(.WIDTH(16), .NUM_REGS(3), .SATURATE(0)) dut3 (
      .Clock(clk), .Reset(rst), .I(data), .FunSel(fs), .RegEn(en[2:0]),
      .OutASel(sel_a), .OutBSel(sel_b), .OutA(a3), .OutB(b3), .Flag(f3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one operation for exactly one rising edge, then return 1 time unit after it.
   task automatic op(input logic [3:0] en_v, input logic [2:0] fs_v, input logic [15:0] d_v);
      @(negedge clk);
      en   = en_v;
      fs   = fs_v;
      data = d_v;
      @(posedge clk);
      #1;
      en = 4'b0000;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = '0; fs = FS_LOAD; data = '0; sel_a = 2'd0; sel_b = 2'd0;
      #3;
      checks++;
      if (a0 !== 16'h0000 || f0 !== 4'b0000) begin
         errors++;
         $display("FAIL reset_init: OutA=%h Flag=%b required 0000 0000", a0, f0);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back('{16'h1234, 1'b0});
      op(4'b0001, FS_LOAD, 16'h1234);
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val) begin
         errors++;
         $display("FAIL reset_load_r0: OutA=%h required %h", a0, e.val);
      end
      op(4'b1000, FS_LOAD, 16'h0001);
      op(4'b1000, FS_SHR, 16'h0000);
      checks++;
      if (f0 !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flag_set: Flag=%b required 1000", f0);
      end
      // Pulse reset between edges; it must take effect without a clock edge.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (a0 !== 16'h0000 || f0 !== 4'b0000) begin
         errors++;
         $display("FAIL reset_async: OutA=%h Flag=%b required 0000 0000", a0, f0);
      end
      #1 rst = 1'b0;
      exp_q.push_back('{16'h0000, 1'b0});
      op(4'b0000, FS_INC, 16'hFFFF);
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || f0 !== 4'b0000) begin
         errors++;
         $display("FAIL reset_hold_disabled: OutA=%h Flag=%b required %h 0000", a0, f0, e.val);
      end
   endtask

   task automatic test_wrap_saturate;
      exp_t es;
      sel_a = 2'd1;
      op(4'b0010, FS_LOAD, 16'hFFFF);
      // First entry is the wrap build, second the saturating build.
      exp_q.push_back('{16'h0000, 1'b1});
      exp_q.push_back('{16'hFFFF, 1'b1});
      op(4'b0010, FS_INC, 16'h0000);
      e = exp_q.pop_front(); es = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || f0[1] !== e.flag) begin
         errors++;
         $display("FAIL inc_wrap: R1=%h Flag1=%b required %h %b", a0, f0[1], e.val, e.flag);
      end
      checks++;
      if (a_s !== es.val || f_s[1] !== es.flag) begin
         errors++;
         $display("FAIL inc_saturate: R1=%h Flag1=%b required %h %b", a_s, f_s[1], es.val, es.flag);
      end
      exp_q.push_back('{16'h0001, 1'b1});
      op(4'b0010, FS_INC, 16'h0000);
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || f0[1] !== e.flag) begin
         errors++;
         $display("FAIL inc_sticky: R1=%h Flag1=%b required %h %b", a0, f0[1], e.val, e.flag);
      end
      exp_q.push_back('{16'h0000, 1'b0});
      op(4'b0010, FS_CLR, 16'h5A5A);
      e = exp_q.pop_front();
      checks++;
      if (a_s !== e.val || f_s[1] !== e.flag) begin
         errors++;
         $display("FAIL clear: R1=%h Flag1=%b required %h %b", a_s, f_s[1], e.val, e.flag);
      end
      exp_q.push_back('{16'hFFFF, 1'b1});
      exp_q.push_back('{16'h0000, 1'b1});
      op(4'b0010, FS_DEC, 16'h0000);
      e = exp_q.pop_front(); es = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || f0[1] !== e.flag) begin
         errors++;
         $display("FAIL dec_wrap: R1=%h Flag1=%b required %h %b", a0, f0[1], e.val, e.flag);
      end
      checks++;
      if (a_s !== es.val || f_s[1] !== es.flag) begin
         errors++;
         $display("FAIL dec_saturate: R1=%h Flag1=%b required %h %b", a_s, f_s[1], es.val, es.flag);
      end
      exp_q.push_back('{16'hFFFE, 1'b1});
      op(4'b0010, FS_DEC, 16'h0000);
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || f0[1] !== e.flag) begin
         errors++;
         $display("FAIL dec_plain: R1=%h Flag1=%b required %h %b", a0, f0[1], e.val, e.flag);
      end
   endtask

   task automatic test_half_loads;
      logic [2:0]  fs_tab  [6] = '{FS_LOAD, FS_LOADL, FS_LOADH, FS_LOAD, FS_SHR, FS_LOADL};
      logic [15:0] d_tab   [6] = '{16'hAAAA, 16'h0055, 16'h00C3, 16'h5555, 16'h0000, 16'h0055};
      logic [15:0] v_tab   [6] = '{16'hAAAA, 16'hAA55, 16'hC355, 16'h5555, 16'h2AAA, 16'h2A55};
      logic        f_tab   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      sel_a = 2'd2;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back('{v_tab[i], f_tab[i]});
         op(4'b0100, fs_tab[i], d_tab[i]);
         e = exp_q.pop_front();
         checks++;
         if (a0 !== e.val || f0[2] !== e.flag) begin
            errors++;
            $display("FAIL half_step%0d: R2=%h Flag2=%b required %h %b", i, a0, f0[2], e.val, e.flag);
         end
      end
      exp_q.push_back('{16'hC355, 1'b1});
      op(4'b0100, FS_LOADH, 16'hFFC3);
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || f0[2] !== e.flag) begin
         errors++;
         $display("FAIL loadh_keeps_flag: R2=%h Flag2=%b required %h %b", a0, f0[2], e.val, e.flag);
      end
   endtask

   task automatic test_shifts;
      logic [2:0]  fs_tab [7] = '{FS_LOAD, FS_SHL, FS_LOAD, FS_SHL, FS_SHR, FS_SHR, FS_SHL};
      logic [15:0] d_tab  [7] = '{16'h8001, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0};
      logic [15:0] v_tab  [7] = '{16'h8001, 16'h0002, 16'h0001, 16'h0002, 16'h0001, 16'h0000, 16'h0000};
      logic        f_tab  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      sel_a = 2'd3;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back('{v_tab[i], f_tab[i]});
         op(4'b1000, fs_tab[i], d_tab[i]);
         e = exp_q.pop_front();
         checks++;
         if (a0 !== e.val || f0[3] !== e.flag) begin
            errors++;
            $display("FAIL shift_step%0d: R3=%h Flag3=%b required %h %b", i, a0, f0[3], e.val, e.flag);
         end
      end
   endtask

   task automatic test_multi_enable;
      op(4'b1010, FS_LOAD, 16'h1111);
      op(4'b1000, FS_LOAD, 16'h3333);
      exp_q.push_back('{16'h00F0, 1'b0});
      op(4'b0101, FS_LOAD, 16'h00F0);
      sel_a = 2'd0; sel_b = 2'd0;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || b0 !== e.val) begin
         errors++;
         $display("FAIL multi_same_reg: OutA=%h OutB=%h required %h", a0, b0, e.val);
      end
      sel_a = 2'd2; sel_b = 2'd1;
      #1;
      checks++;
      if (a0 !== 16'h00F0 || b0 !== 16'h1111) begin
         errors++;
         $display("FAIL multi_r2_r1: R2=%h R1=%h required 00f0 1111", a0, b0);
      end
      sel_b = 2'd3;
      #1;
      checks++;
      if (b0 !== 16'h3333) begin
         errors++;
         $display("FAIL multi_isolation_r3: R3=%h required 3333", b0);
      end
   endtask

   task automatic test_read_during_write;
      sel_a = 2'd1; sel_b = 2'd3;
      op(4'b0010, FS_LOAD, 16'h0007);
      exp_q.push_back('{16'h0007, 1'b0});
      exp_q.push_back('{16'h0008, 1'b0});
      @(negedge clk);
      en = 4'b0010; fs = FS_INC;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val) begin
         errors++;
         $display("FAIL rdw_pre_edge: OutA=%h required %h", a0, e.val);
      end
      @(posedge clk);
      #1;
      en = 4'b0000;
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val || a3 !== e.val) begin
         errors++;
         $display("FAIL rdw_post_edge: OutA=%h OutA3=%h required %h", a0, a3, e.val);
      end
      checks++;
      if (b3 !== 16'h0000) begin
         errors++;
         $display("FAIL sel_out_of_range: OutB=%h required 0000", b3);
      end
      exp_q.push_back('{16'h0008, 1'b0});
      op(4'b0000, FS_LOAD, 16'hFFFF);
      e = exp_q.pop_front();
      checks++;
      if (a0 !== e.val) begin
         errors++;
         $display("FAIL regen_zero_hold: OutA=%h required %h", a0, e.val);
      end
   endtask

   initial begin
      test_reset();
      test_wrap_saturate();
      test_half_loads();
      test_shifts();
      test_multi_enable();
      test_read_during_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
